// File: rtl/io_fifo_bank.sv
// rtl/io_fifo_bank.sv - bank of per-channel bidirectional IO FIFOs with one-cycle direction flush
// Optional macro IO_FIFO_BANK_OVERFLOW_EN enables sticky per-channel outbound overflow flags.
module io_fifo_bank #(
  parameter int PORTS      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORTS-1:0]                  core_dir,
  input  logic [PORTS-1:0]                  core_out_valid,
  input  logic [PORTS*DATA_WIDTH-1:0]       core_out_data,
  output logic [PORTS-1:0]                  core_in_valid,
  output logic [PORTS*DATA_WIDTH-1:0]       core_in_data,
  input  logic [PORTS-1:0]                  core_in_ack,
  input  logic [PORTS-1:0]                  ext_in_valid,
  output logic [PORTS-1:0]                  ext_in_ready,
  input  logic [PORTS*DATA_WIDTH-1:0]       ext_in_data,
  output logic [PORTS-1:0]                  ext_out_valid,
  input  logic [PORTS-1:0]                  ext_out_ready,
  output logic [PORTS*DATA_WIDTH-1:0]       ext_out_data,
  output logic [PORTS*(PTR_WIDTH+1)-1:0]    level,
  output logic [PORTS-1:0]                  overflow,
  input  logic [PORTS-1:0]                  ovf_clear
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH);

`ifndef IO_FIFO_BANK_OVERFLOW_EN
  logic unused_ovf_clear;
  assign unused_ovf_clear = ^ovf_clear;
`endif

  for (genvar p = 0; p < PORTS; p++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH:0]    count;
    logic                  dir_q;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic                  out_mode;
    logic                  in_mode;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] wdata;

    // Handshakes are only live when the channel is settled in one direction and not in reset.
    always_comb begin
      flush    = core_dir[p] != dir_q;
      full     = count == FULL_CNT;
      empty    = count == '0;
      out_mode = !rst && !flush && dir_q;
      in_mode  = !rst && !flush && !dir_q;
      push     = !full && ((out_mode && core_out_valid[p]) || (in_mode && ext_in_valid[p]));
      pop      = !empty && ((out_mode && ext_out_ready[p]) || (in_mode && core_in_ack[p]));
      wdata    = dir_q ? core_out_data[p*DATA_WIDTH +: DATA_WIDTH]
                       : ext_in_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    assign ext_out_valid[p] = out_mode && !empty;
    assign ext_in_ready[p]  = in_mode && !full;
    assign core_in_valid[p] = in_mode && !empty;
    assign ext_out_data[p*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];
    assign core_in_data[p*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];
    assign level[p*(PTR_WIDTH+1) +: (PTR_WIDTH+1)]  = count;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        dir_q  <= 1'b1;
      end else if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        dir_q  <= core_dir[p];
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

`ifdef IO_FIFO_BANK_OVERFLOW_EN
    logic drop;
    logic ovf_q;
    assign drop = out_mode && core_out_valid[p] && full;

    always_ff @(posedge clk) begin
      if (rst)               ovf_q <= 1'b0;
      else if (drop)         ovf_q <= 1'b1;
      else if (ovf_clear[p]) ovf_q <= 1'b0;
    end
    assign overflow[p] = ovf_q;
`else
    assign overflow[p] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_io_fifo_bank.sv
// tb/tb_io_fifo_bank.sv - directed self-checking bench for io_fifo_bank
module tb_io_fifo_bank;
  localparam int PORTS = 16;
  localparam int DW    = 16;
  localparam int PW    = 2;
  localparam int LW    = PW + 1;
`ifdef IO_FIFO_BANK_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [PORTS-1:0]    core_dir, core_out_valid, core_in_valid, core_in_ack;
  logic [PORTS-1:0]    ext_in_valid, ext_in_ready, ext_out_valid, ext_out_ready;
  logic [PORTS-1:0]    overflow, ovf_clear;
  logic [PORTS*DW-1:0] core_out_data, core_in_data, ext_in_data, ext_out_data;
  logic [PORTS*LW-1:0] level;

  int checks = 0;
  int errors = 0;

  io_fifo_bank #(.PORTS(PORTS), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .PTR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .core_dir(core_dir),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .core_in_valid(core_in_valid), .core_in_data(core_in_data), .core_in_ack(core_in_ack),
    .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready), .ext_in_data(ext_in_data),
    .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready), .ext_out_data(ext_out_data),
    .level(level), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lvl(input int p);
    return level[p*LW +: LW];
  endfunction

  function automatic logic [DW-1:0] word(input logic [PORTS*DW-1:0] bus, input int p);
    return bus[p*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %h exp 0", level); end
    checks++; if (overflow !== '0) begin errors++; $display("FAIL reset_overflow got %h exp 0", overflow); end
    checks++; if (ext_out_valid !== '0 || core_in_valid !== '0 || ext_in_ready !== '0) begin
      errors++; $display("FAIL reset_handshake got %h/%h/%h exp 0/0/0", ext_out_valid, core_in_valid, ext_in_ready);
    end
  endtask

  task automatic test_outbound_fill();
    for (int i = 0; i < 5; i++) begin
      core_out_valid[3] = 1'b1;
      core_out_data[3*DW +: DW] = 16'(100 * (i + 1));
      tick();
    end
    core_out_valid[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd4) begin errors++; $display("FAIL fill_level got %0d exp 4", lvl(3)); end
    checks++; if (overflow[3] !== OVF) begin errors++; $display("FAIL fill_overflow got %0d exp %0d", overflow[3], OVF); end
    checks++; if (ext_in_ready[3] !== 1'b0 || core_in_valid[3] !== 1'b0) begin
      errors++; $display("FAIL fill_inbound_idle got %0d/%0d exp 0/0", ext_in_ready[3], core_in_valid[3]);
    end
    ext_out_ready[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ext_out_valid[3] !== 1'b1 || word(ext_out_data, 3) !== 16'(100 * (i + 1))) begin
        errors++; $display("FAIL drain_word%0d got v=%0d d=%0d exp v=1 d=%0d", i, ext_out_valid[3], word(ext_out_data, 3), 100 * (i + 1));
      end
      tick();
    end
    ext_out_ready[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd0 || ext_out_valid[3] !== 1'b0) begin
      errors++; $display("FAIL drain_empty got lvl=%0d v=%0d exp 0/0", lvl(3), ext_out_valid[3]);
    end
    ovf_clear[3] = 1'b1;
    tick();
    ovf_clear[3] = 1'b0;
    #1;
    checks++; if (overflow[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0d exp 0", overflow[3]); end
  endtask

  task automatic test_inbound();
    core_dir[3] = 1'b0;
    #1;
    checks++; if (ext_in_ready[3] !== 1'b0 || core_in_valid[3] !== 1'b0 || ext_out_valid[3] !== 1'b0) begin
      errors++; $display("FAIL in_flush_handshake got %0d/%0d/%0d exp 0/0/0", ext_in_ready[3], core_in_valid[3], ext_out_valid[3]);
    end
    tick();
    ext_in_valid[3] = 1'b1;
    ext_in_data[3*DW +: DW] = 16'd1234;
    #1;
    checks++; if (ext_in_ready[3] !== 1'b1 || core_in_valid[3] !== 1'b0) begin
      errors++; $display("FAIL in_ready got r=%0d v=%0d exp 1/0", ext_in_ready[3], core_in_valid[3]);
    end
    tick();
    ext_in_data[3*DW +: DW] = 16'd5678;
    #1;
    checks++; if (core_in_valid[3] !== 1'b1 || word(core_in_data, 3) !== 16'd1234) begin
      errors++; $display("FAIL in_first got v=%0d d=%0d exp 1/1234", core_in_valid[3], word(core_in_data, 3));
    end
    tick();
    ext_in_valid[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd2) begin errors++; $display("FAIL in_level2 got %0d exp 2", lvl(3)); end
    core_in_ack[3] = 1'b1;
    tick();
    checks++; if (core_in_valid[3] !== 1'b1 || word(core_in_data, 3) !== 16'd5678) begin
      errors++; $display("FAIL in_second got v=%0d d=%0d exp 1/5678", core_in_valid[3], word(core_in_data, 3));
    end
    tick();
    core_in_ack[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd0 || core_in_valid[3] !== 1'b0) begin
      errors++; $display("FAIL in_empty got lvl=%0d v=%0d exp 0/0", lvl(3), core_in_valid[3]);
    end
  endtask

  task automatic test_full_backpressure();
    ext_in_valid[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_in_data[3*DW +: DW] = 16'(10 + i);
      tick();
    end
    ext_in_valid[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd4 || ext_in_ready[3] !== 1'b0) begin
      errors++; $display("FAIL bp_full got lvl=%0d r=%0d exp 4/0", lvl(3), ext_in_ready[3]);
    end
    ext_in_valid[3] = 1'b1;
    ext_in_data[3*DW +: DW] = 16'd99;
    core_in_ack[3] = 1'b1;
    #1;
    checks++; if (ext_in_ready[3] !== 1'b0 || word(core_in_data, 3) !== 16'd10) begin
      errors++; $display("FAIL bp_popcycle got r=%0d d=%0d exp 0/10", ext_in_ready[3], word(core_in_data, 3));
    end
    tick();
    ext_in_valid[3] = 1'b0;
    core_in_ack[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd3 || ext_in_ready[3] !== 1'b1) begin
      errors++; $display("FAIL bp_after got lvl=%0d r=%0d exp 3/1", lvl(3), ext_in_ready[3]);
    end
    core_in_ack[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (word(core_in_data, 3) !== 16'(11 + i)) begin
        errors++; $display("FAIL bp_drain%0d got %0d exp %0d", i, word(core_in_data, 3), 11 + i);
      end
      tick();
    end
    core_in_ack[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd0 || core_in_valid[3] !== 1'b0) begin
      errors++; $display("FAIL bp_empty got lvl=%0d v=%0d exp 0/0", lvl(3), core_in_valid[3]);
    end
  endtask

  task automatic test_dir_flip();
    core_out_valid[5] = 1'b1;
    core_out_data[5*DW +: DW] = 16'd7;
    tick();
    core_out_data[5*DW +: DW] = 16'd8;
    tick();
    core_out_valid[5] = 1'b0;
    #1;
    checks++; if (lvl(5) !== 3'd2 || ext_out_valid[5] !== 1'b1) begin
      errors++; $display("FAIL flip_pre got lvl=%0d v=%0d exp 2/1", lvl(5), ext_out_valid[5]);
    end
    core_dir[5] = 1'b0;
    ext_out_ready[5] = 1'b1;
    #1;
    checks++; if (ext_out_valid[5] !== 1'b0 || ext_in_ready[5] !== 1'b0 || core_in_valid[5] !== 1'b0) begin
      errors++; $display("FAIL flip_handshake got %0d/%0d/%0d exp 0/0/0", ext_out_valid[5], ext_in_ready[5], core_in_valid[5]);
    end
    checks++; if (ext_in_ready[3] !== 1'b1) begin errors++; $display("FAIL flip_neighbour got %0d exp 1", ext_in_ready[3]); end
    tick();
    ext_out_ready[5] = 1'b0;
    #1;
    checks++; if (lvl(5) !== 3'd0 || ext_in_ready[5] !== 1'b1) begin
      errors++; $display("FAIL flip_post got lvl=%0d r=%0d exp 0/1", lvl(5), ext_in_ready[5]);
    end
    ext_in_valid[5] = 1'b1;
    ext_in_data[5*DW +: DW] = 16'd42;
    tick();
    ext_in_valid[5] = 1'b0;
    #1;
    checks++; if (core_in_valid[5] !== 1'b1 || word(core_in_data, 5) !== 16'd42) begin
      errors++; $display("FAIL flip_inbound got v=%0d d=%0d exp 1/42", core_in_valid[5], word(core_in_data, 5));
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      core_out_valid[0] = 1'b1;
      core_out_valid[7] = (i < 2);
      core_out_data[0*DW +: DW] = 16'(i + 1);
      core_out_data[7*DW +: DW] = 16'(i + 20);
      tick();
    end
    core_out_valid = '0;
    #1;
    checks++; if (lvl(0) !== 3'd4 || lvl(7) !== 3'd2 || overflow[0] !== OVF) begin
      errors++; $display("FAIL rm_pre got l0=%0d l7=%0d o=%0d exp 4/2/%0d", lvl(0), lvl(7), overflow[0], OVF);
    end
    rst = 1'b1;
    core_dir = '1;
    ext_out_ready[0] = 1'b1;
    #1;
    checks++; if (ext_out_valid !== '0 || ext_in_ready !== '0 || core_in_valid !== '0) begin
      errors++; $display("FAIL rm_during got %h/%h/%h exp 0/0/0", ext_out_valid, ext_in_ready, core_in_valid);
    end
    tick();
    rst = 1'b0;
    ext_out_ready[0] = 1'b0;
    #1;
    checks++; if (level !== '0 || overflow !== '0 || ext_out_valid !== '0) begin
      errors++; $display("FAIL rm_after got lvl=%h o=%h v=%h exp 0/0/0", level, overflow, ext_out_valid);
    end
    core_out_valid[3] = 1'b1;
    core_out_data[3*DW +: DW] = 16'd55;
    tick();
    core_out_data[3*DW +: DW] = 16'd66;
    ext_out_ready[3] = 1'b1;
    #1;
    checks++; if (lvl(3) !== 3'd1 || word(ext_out_data, 3) !== 16'd55) begin
      errors++; $display("FAIL rm_dir1 got lvl=%0d d=%0d exp 1/55", lvl(3), word(ext_out_data, 3));
    end
    tick();
    core_out_valid[3] = 1'b0;
    ext_out_ready[3] = 1'b0;
    #1;
    checks++; if (lvl(3) !== 3'd1 || word(ext_out_data, 3) !== 16'd66) begin
      errors++; $display("FAIL b2b_pushpop got lvl=%0d d=%0d exp 1/66", lvl(3), word(ext_out_data, 3));
    end
  endtask

  initial begin
    rst = 1'b1;
    core_dir = '1;
    core_out_valid = '0; core_out_data = '0; core_in_ack = '0;
    ext_in_valid = '0; ext_in_data = '0; ext_out_ready = '0; ovf_clear = '0;
    test_reset();
    test_outbound_fill();
    test_inbound();
    test_full_backpressure();
    test_dir_flip();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
